reg_write_buffer: RTL and testbench

Write-back initiator for the register file write port. Accepts register write requests from the pipeline's write-back stage over a valid/ready handshake and queues them in a small FIFO. Drains one entry per enabled cycle onto the register file's `write_reg`/`write_data`/`write_reg_en` port. Provides combinational bypass lookups so the read side sees pending writes before they commit.

---
 rtl/reg_write_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_reg_write_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_buffer.sv
// reg_write_buffer: queues register write-back requests in a small FIFO and drains one entry
// per enabled cycle onto the register file write port. Combinational bypass lookups expose
// pending writes (buffered entries plus the output stage) to the read side.
//
// Optional feature: define WB_COALESCE_EN to merge a push into the youngest buffered entry
// that targets the same register instead of allocating a new slot.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   in_valid/in_ready    request handshake; in_reg/in_data carry the write
//   drain_en             register file port available this cycle
//   write_reg/_data/_en  registered register file write port
//   lookup_reg1/2        bypass lookup indices; hit1/2, hit_data1/2 results
//   count, full, empty   FIFO occupancy (output stage excluded)
module reg_write_buffer #(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned ID_LENGTH   = 4,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ID_LENGTH-1:0]     in_reg,
  input  logic [WORD_LENGTH-1:0]   in_data,
  input  logic                     drain_en,
  output logic [ID_LENGTH-1:0]     write_reg,
  output logic [WORD_LENGTH-1:0]   write_data,
  output logic                     write_reg_en,
  input  logic [ID_LENGTH-1:0]     lookup_reg1,
  input  logic [ID_LENGTH-1:0]     lookup_reg2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [WORD_LENGTH-1:0]   hit_data1,
  output logic [WORD_LENGTH-1:0]   hit_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e state_q, state_d;

  logic [ID_LENGTH-1:0]   mem_reg_q  [DEPTH];
  logic [WORD_LENGTH-1:0] mem_data_q [DEPTH];
  logic [PtrW-1:0]        head_q, tail_q;
  logic [CntW-1:0]        count_q, count_d;
  logic [ID_LENGTH-1:0]   write_reg_q;
  logic [WORD_LENGTH-1:0] write_data_q;
  logic                   write_reg_en_q;

  logic                   push, pop, alloc, coal_hit;
  logic [PtrW-1:0]        slot_idx   [DEPTH];
  logic                   slot_valid [DEPTH];

  assign in_ready = rst & (state_q != StFull);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q != StEmpty) & drain_en;
  // Register 0 is hardwired, so its writes are accepted but never stored.
  assign alloc    = push & (in_reg != '0) & ~coal_hit;

  // Slot i is the i-th oldest buffered entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_idx[i]   = head_q + PtrW'(i);
      slot_valid[i] = CntW'(i) < count_q;
    end
  end

`ifdef WB_COALESCE_EN
  logic [PtrW-1:0] coal_idx;

  // Scan oldest to youngest so the youngest match wins. The head is excluded while it is
  // popping, since it leaves the buffer at this edge.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (mem_reg_q[slot_idx[i]] == in_reg) && !(i == 0 && pop)) begin
        coal_hit = 1'b1;
        coal_idx = slot_idx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_reg_q[tail_q]  <= in_reg;
      mem_data_q[tail_q] <= in_data;
    end else if (push && (in_reg != '0) && coal_hit) begin
      mem_data_q[coal_idx] <= in_data;
    end
  end
`else
  assign coal_hit = 1'b0;

  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_reg_q[tail_q]  <= in_reg;
      mem_data_q[tail_q] <= in_data;
    end
  end
`endif

  always_comb begin
    count_d = count_q;
    unique case ({alloc, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      write_reg_en_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
    end else begin
      if (alloc) tail_q <= tail_q + PtrW'(1);
      if (pop)   head_q <= head_q + PtrW'(1);
      count_q        <= count_d;
      write_reg_en_q <= pop;
      if (pop) begin
        write_reg_q  <= mem_reg_q[head_q];
        write_data_q <= mem_data_q[head_q];
      end
    end
  end

  // Occupancy FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StEmpty;
    else      state_q <= state_d;
  end

  // Occupancy FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (alloc) state_d = StPartial;
      end
      StPartial: begin
        if (alloc && !pop && (count_q == CntW'(DEPTH - 1))) state_d = StFull;
        else if (pop && !alloc && (count_q == CntW'(1)))   state_d = StEmpty;
      end
      StFull: begin
        if (pop && !alloc) state_d = StPartial;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Occupancy FSM: outputs.
  always_comb begin
    full  = (state_q == StFull);
    empty = (state_q == StEmpty);
  end

  assign count        = count_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign write_reg_en = write_reg_en_q;

  // Bypass: output stage has lowest priority, then buffered entries oldest to youngest so the
  // youngest match overrides.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    hit_data1 = '0;
    hit_data2 = '0;
    if (write_reg_en_q) begin
      if ((lookup_reg1 != '0) && (write_reg_q == lookup_reg1)) begin
        hit1      = 1'b1;
        hit_data1 = write_data_q;
      end
      if ((lookup_reg2 != '0) && (write_reg_q == lookup_reg2)) begin
        hit2      = 1'b1;
        hit_data2 = write_data_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (lookup_reg1 != '0) && (mem_reg_q[slot_idx[i]] == lookup_reg1)) begin
        hit1      = 1'b1;
        hit_data1 = mem_data_q[slot_idx[i]];
      end
      if (slot_valid[i] && (lookup_reg2 != '0) && (mem_reg_q[slot_idx[i]] == lookup_reg2)) begin
        hit2      = 1'b1;
        hit_data2 = mem_data_q[slot_idx[i]];
      end
    end
  end

endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed testbench for reg_write_buffer (default parameters).
module tb_reg_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        write_reg_en;
  logic [3:0]  lookup_reg1, lookup_reg2;
  logic        hit1, hit2;
  logic [15:0] hit_data1, hit_data2;
  logic [2:0]  count;
  logic        full, empty;

  int n_tests = 0;
  int n_fail  = 0;

  reg_write_buffer #(.WORD_LENGTH(16), .ID_LENGTH(4), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg       (in_reg),
    .in_data      (in_data),
    .drain_en     (drain_en),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_reg_en (write_reg_en),
    .lookup_reg1  (lookup_reg1),
    .lookup_reg2  (lookup_reg2),
    .hit1         (hit1),
    .hit2         (hit2),
    .hit_data1    (hit_data1),
    .hit_data2    (hit_data2),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; drain_en = 1'b0;
    lookup_reg1 = 4'd3; lookup_reg2 = 4'd0;
    step(); step();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_in_ready_low: got %b exp 0", in_ready); end
    rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    n_tests++; if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL reset_occupancy: got cnt=%0d e=%b f=%b exp 0 1 0", count, empty, full); end
    n_tests++; if ({write_reg_en, write_reg, write_data} !== 21'd0) begin n_fail++;
      $display("FAIL reset_port: got en=%b r=%0d d=%h exp 0 0 0", write_reg_en, write_reg,
               write_data); end
    n_tests++; if ({hit1, hit_data1} !== 17'd0) begin n_fail++;
      $display("FAIL reset_hit: got %b %h exp 0 0", hit1, hit_data1); end
  endtask

  task automatic test_single();
    drain_en = 1'b1; in_valid = 1'b1; in_reg = 4'd3; in_data = 16'h00AA;
    step();
    in_valid = 1'b0;
    lookup_reg1 = 4'd3;
    #1;
    n_tests++; if ({count, write_reg_en} !== {3'd1, 1'b0}) begin n_fail++;
      $display("FAIL single_pushed: got cnt=%0d en=%b exp 1 0", count, write_reg_en); end
    n_tests++; if ({hit1, hit_data1} !== {1'b1, 16'h00AA}) begin n_fail++;
      $display("FAIL single_bypass: got %b %h exp 1 00aa", hit1, hit_data1); end
    step();
    n_tests++; if ({write_reg_en, write_reg, write_data, count} !== {1'b1, 4'd3, 16'h00AA, 3'd0})
    begin n_fail++;
      $display("FAIL single_commit: got en=%b r=%0d d=%h cnt=%0d exp 1 3 00aa 0", write_reg_en,
               write_reg, write_data, count); end
    step();
    n_tests++; if ({write_reg_en, write_reg, write_data} !== {1'b0, 4'd3, 16'h00AA}) begin
      n_fail++;
      $display("FAIL single_hold: got en=%b r=%0d d=%h exp 0 3 00aa", write_reg_en, write_reg,
               write_data); end
  endtask

  task automatic test_full();
    drain_en = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      in_valid = 1'b1; in_reg = 4'(r); in_data = 16'(r * 16'h0100);
      step();
    end
    in_reg = 4'd5; in_data = 16'h5555;
    lookup_reg2 = 4'd4;
    #1;
    n_tests++; if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4}) begin n_fail++;
      $display("FAIL full_flags: got f=%b rdy=%b cnt=%0d exp 1 0 4", full, in_ready, count); end
    n_tests++; if ({hit2, hit_data2} !== {1'b1, 16'h0400}) begin n_fail++;
      $display("FAIL full_lookup2: got %b %h exp 1 0400", hit2, hit_data2); end
    step();
    in_valid = 1'b0;
    n_tests++; if (count !== 3'd4) begin n_fail++;
      $display("FAIL full_ignored: got cnt=%0d exp 4", count); end
    drain_en = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      step();
      n_tests++; if ({write_reg_en, write_reg, write_data} !== {1'b1, 4'(r), 16'(r * 16'h0100)})
      begin n_fail++;
        $display("FAIL full_order%0d: got en=%b r=%0d d=%h exp 1 %0d %h", r, write_reg_en,
                 write_reg, write_data, r, r * 16'h0100); end
    end
    step();
    n_tests++; if ({write_reg_en, empty, count} !== {1'b0, 1'b1, 3'd0}) begin n_fail++;
      $display("FAIL full_drained: got en=%b e=%b cnt=%0d exp 0 1 0", write_reg_en, empty,
               count); end
  endtask

  task automatic test_dup();
    logic [2:0]  exp_cnt;
    logic [15:0] exp_first;
`ifdef WB_COALESCE_EN
    exp_cnt = 3'd1; exp_first = 16'h2222;
`else
    exp_cnt = 3'd2; exp_first = 16'h1111;
`endif
    drain_en = 1'b0; in_valid = 1'b1; in_reg = 4'd5; in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    in_valid = 1'b0; lookup_reg1 = 4'd5;
    #1;
    n_tests++; if ({hit1, hit_data1, count} !== {1'b1, 16'h2222, exp_cnt}) begin n_fail++;
      $display("FAIL dup_lookup: got %b %h cnt=%0d exp 1 2222 %0d", hit1, hit_data1, count,
               exp_cnt); end
    drain_en = 1'b1;
    step();
    n_tests++; if ({write_reg_en, write_data} !== {1'b1, exp_first}) begin n_fail++;
      $display("FAIL dup_commit1: got en=%b d=%h exp 1 %h", write_reg_en, write_data,
               exp_first); end
`ifndef WB_COALESCE_EN
    step();
    n_tests++; if ({write_reg_en, write_data} !== {1'b1, 16'h2222}) begin n_fail++;
      $display("FAIL dup_commit2: got en=%b d=%h exp 1 2222", write_reg_en, write_data); end
`endif
    // Only the output stage still holds reg 5.
    n_tests++; if ({hit1, hit_data1} !== {1'b1, 16'h2222}) begin n_fail++;
      $display("FAIL dup_outstage_hit: got %b %h exp 1 2222", hit1, hit_data1); end
    step();
    n_tests++; if ({write_reg_en, hit1, hit_data1} !== {1'b0, 1'b0, 16'h0000}) begin n_fail++;
      $display("FAIL dup_done: got en=%b hit=%b d=%h exp 0 0 0", write_reg_en, hit1,
               hit_data1); end
  endtask

  task automatic test_reg_zero();
    drain_en = 1'b1; in_valid = 1'b1; in_reg = 4'd0; in_data = 16'hFFFF;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL zero_ready: got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; lookup_reg1 = 4'd0;
    #1;
    n_tests++; if ({count, hit1, hit_data1} !== {3'd0, 1'b0, 16'h0000}) begin n_fail++;
      $display("FAIL zero_discard: got cnt=%0d hit=%b d=%h exp 0 0 0", count, hit1,
               hit_data1); end
    step();
    n_tests++; if (write_reg_en !== 1'b0) begin n_fail++;
      $display("FAIL zero_no_commit: got %b exp 0", write_reg_en); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] q[$];
    logic [19:0] exp;
    drain_en = 1'b0; in_valid = 1'b1;
    in_reg = 4'd6; in_data = 16'h0A01; step(); q.push_back({4'd6, 16'h0A01});
    in_reg = 4'd7; in_data = 16'h0A02; step(); q.push_back({4'd7, 16'h0A02});
    n_tests++; if (count !== 3'd2) begin n_fail++;
      $display("FAIL b2b_prefill: got cnt=%0d exp 2", count); end
    drain_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_reg = 4'(8 + k); in_data = 16'(16'h0B00 + k);
      step();
      q.push_back({4'(8 + k), 16'(16'h0B00 + k)});
      exp = q.pop_front();
      n_tests++; if ({write_reg_en, write_reg, write_data, count} !== {1'b1, exp, 3'd2}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got en=%b r=%0d d=%h cnt=%0d exp 1 %0d %h 2", k,
                 write_reg_en, write_reg, write_data, count, exp[19:16], exp[15:0]); end
    end
    in_valid = 1'b0; drain_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_reg = 4'd1; in_data = 16'hC001; drain_en = 1'b0;
    step();
    in_reg = 4'd2; in_data = 16'hC002; drain_en = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if ({count, write_reg_en} !== {3'd3, 1'b1}) begin n_fail++;
      $display("FAIL mid_setup: got cnt=%0d en=%b exp 3 1", count, write_reg_en); end
    rst = 1'b0; lookup_reg1 = 4'd14; lookup_reg2 = 4'd2;
    step();
    n_tests++; if ({count, empty, full, write_reg_en, write_reg, write_data, in_ready} !==
                   {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0}) begin n_fail++;
      $display("FAIL mid_reset_state: got cnt=%0d e=%b f=%b en=%b r=%0d d=%h rdy=%b",
               count, empty, full, write_reg_en, write_reg, write_data, in_ready); end
    n_tests++; if ({hit1, hit_data1, hit2, hit_data2} !== 34'd0) begin n_fail++;
      $display("FAIL mid_reset_hits: got %b %h %b %h exp all 0", hit1, hit_data1, hit2,
               hit_data2); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++; if ({write_reg_en, count} !== {1'b0, 3'd0}) begin n_fail++;
        $display("FAIL mid_after%0d: got en=%b cnt=%0d exp 0 0", k, write_reg_en, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_dup();
    test_reg_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
